// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for data_mem_arbiter: core load/store path, DMA/debug requester
// and the shared data-memory port, plus an owner debug tap.
//
// DMA handshake: a beat transfers on a rising clk edge when dmaValid && dmaReady
// are both high. The requester holds dmaWe/dmaAddr/dmaWdata stable while
// dmaValid is high and the beat is not yet accepted; dmaReady never depends
// on the beat's payload. A read beat returns dmaRdata with a one-cycle
// dmaRvalid pulse on the edge after acceptance.
interface data_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // core side
  logic                  coreReq;
  logic                  coreWe;
  logic [ADDR_WIDTH-1:0] coreAddr;
  logic [DATA_WIDTH-1:0] coreWdata;
  logic [DATA_WIDTH-1:0] coreRdata;
  logic                  coreStall;
  // DMA / debug side
  logic                  dmaValid;
  logic                  dmaReady;
  logic                  dmaWe;
  logic [ADDR_WIDTH-1:0] dmaAddr;
  logic [DATA_WIDTH-1:0] dmaWdata;
  logic [DATA_WIDTH-1:0] dmaRdata;
  logic                  dmaRvalid;
  // memory side
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic                  memWe;
  logic [DATA_WIDTH-1:0] memRdata;
  // status / debug
  logic [31:0]           stallCount;
  logic                  ownerDbg;   // 0 = core owns the port, 1 = DMA owns it

  // arbiter view
  modport slave (
    input  coreReq, coreWe, coreAddr, coreWdata,
    output coreRdata, coreStall,
    input  dmaValid, dmaWe, dmaAddr, dmaWdata,
    output dmaReady, dmaRdata, dmaRvalid,
    output memAddr, memWdata, memWe,
    input  memRdata,
    output stallCount, ownerDbg
  );

  // environment view (core, DMA and memory models)
  modport master (
    output coreReq, coreWe, coreAddr, coreWdata,
    input  coreRdata, coreStall,
    output dmaValid, dmaWe, dmaAddr, dmaWdata,
    input  dmaReady, dmaRdata, dmaRvalid,
    input  memAddr, memWdata, memWe,
    output memRdata,
    input  stallCount, ownerDbg
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Data-memory port arbiter between the single-cycle core and a DMA/debug
// requester. Core has default priority; a waiting DMA is forced in after
// STARVE_LIMIT blocked cycles and is bounded to MAX_BURST beats while the core
// keeps requesting. The core is stalled whenever DMA owns the port.
// Optional macro ARB_STALL_COUNT_EN: enables the saturating stallCount counter;
// otherwise stallCount is tied to zero.
module data_mem_arbiter #(
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               reset,
  data_mem_arbiter_if.slave bus
);
  localparam int WAIT_W  = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(STARVE_LIMIT - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  typedef enum logic {OWN_CORE = 1'b0, OWN_DMA = 1'b1} owner_t;

  owner_t             owner, owner_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic [BURST_W-1:0] burst_cnt, burst_nxt;
  logic               dma_ready;
  logic               core_stall;
  logic               dma_rd_accept;

  // Port mux: the owner alone drives address, data and write enable
  assign dma_ready       = (owner == OWN_DMA);
  assign core_stall      = (owner == OWN_DMA) && bus.coreReq;
  assign dma_rd_accept   = bus.dmaValid && dma_ready && !bus.dmaWe;
  assign bus.dmaReady    = dma_ready;
  assign bus.coreStall   = core_stall;
  assign bus.coreRdata   = bus.memRdata;
  assign bus.memAddr     = dma_ready ? bus.dmaAddr  : bus.coreAddr;
  assign bus.memWdata    = dma_ready ? bus.dmaWdata : bus.coreWdata;
  assign bus.memWe       = dma_ready ? (bus.dmaValid && bus.dmaWe)
                                     : (bus.coreReq && bus.coreWe);
  assign bus.ownerDbg    = (owner == OWN_DMA);

  // Owner state and wait/burst counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_CORE;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      owner     <= owner_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Next owner: idle core yields at once; busy core yields after the starve
  // window; DMA yields when it drops valid or hits the burst cap under core load
  always_comb begin
    owner_nxt = owner;
    wait_nxt  = wait_cnt;
    burst_nxt = burst_cnt;
    unique case (owner)
      OWN_CORE: begin
        burst_nxt = '0;
        if (bus.dmaValid) begin
          if (!bus.coreReq || (wait_cnt == WAIT_LAST)) begin
            owner_nxt = OWN_DMA;
            wait_nxt  = '0;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end else begin
          wait_nxt = '0;
        end
      end
      OWN_DMA: begin
        wait_nxt = '0;
        if (!bus.dmaValid) begin
          owner_nxt = OWN_CORE;
          burst_nxt = '0;
        end else if (burst_cnt == BURST_LAST) begin
          // cap only matters while the core is waiting; otherwise saturate
          if (bus.coreReq) begin
            owner_nxt = OWN_CORE;
            burst_nxt = '0;
          end
        end else begin
          burst_nxt = burst_cnt + BURST_W'(1);
        end
      end
      default: owner_nxt = OWN_CORE;
    endcase
  end

  // Registered DMA read return: capture memory data on an accepted read beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.dmaRdata  <= '0;
      bus.dmaRvalid <= 1'b0;
    end else begin
      bus.dmaRvalid <= dma_rd_accept;
      if (dma_rd_accept) bus.dmaRdata <= bus.memRdata;
    end
  end

`ifdef ARB_STALL_COUNT_EN
  // Saturating count of cycles the core spent stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.stallCount <= '0;
    end else if (core_stall && (bus.stallCount != 32'hFFFF_FFFF)) begin
      bus.stallCount <= bus.stallCount + 32'd1;
    end
  end
`else
  assign bus.stallCount = '0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter (MAX_BURST=4, STARVE_LIMIT=8) with a
// combinational-read / synchronous-write memory model on the memory port.
module tb_data_mem_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  logic [31:0] exp_stall_count;

  data_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  data_mem_arbiter #(.MAX_BURST(4), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  assign bus.memRdata = mem[bus.memAddr[7:2]];
  always @(posedge clk) if (bus.memWe) mem[bus.memAddr[7:2]] <= bus.memWdata;

  // one cycle; inputs are changed and outputs sampled 1ns+ after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.coreReq  = 1'b0;
    bus.coreWe   = 1'b0;
    bus.coreAddr = 32'h0;
    bus.coreWdata = 32'h0;
    bus.dmaValid = 1'b0;
    bus.dmaWe    = 1'b0;
    bus.dmaAddr  = 32'h0;
    bus.dmaWdata = 32'h0;
  endtask

  task automatic pulse_reset();
    tick();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    bus.coreReq = 1'b1; bus.coreWe = 1'b1; bus.coreAddr = 32'h70; bus.coreWdata = 32'h5;
    #3;
    n_checks++; if (bus.ownerDbg !== 1'b0) $display("FAIL rst_owner: got %0b want 0", bus.ownerDbg); else n_pass++;
    n_checks++; if (bus.dmaReady !== 1'b0) $display("FAIL rst_ready: got %0b want 0", bus.dmaReady); else n_pass++;
    n_checks++; if (bus.coreStall !== 1'b0) $display("FAIL rst_stall: got %0b want 0", bus.coreStall); else n_pass++;
    n_checks++; if (bus.dmaRvalid !== 1'b0) $display("FAIL rst_rvalid: got %0b want 0", bus.dmaRvalid); else n_pass++;
    n_checks++; if (bus.dmaRdata !== 32'h0) $display("FAIL rst_rdata: got %0h want 0", bus.dmaRdata); else n_pass++;
    n_checks++; if (bus.stallCount !== 32'h0) $display("FAIL rst_stallcnt: got %0d want 0", bus.stallCount); else n_pass++;
    n_checks++; if (bus.memWe !== 1'b1) $display("FAIL rst_memwe: got %0b want 1", bus.memWe); else n_pass++;
    tick();
    tick();
    reset = 1'b1;
    drive_idle();
  endtask

  task automatic test_dma_write_idle();
    tick();
    bus.dmaValid = 1'b1; bus.dmaWe = 1'b1; bus.dmaAddr = 32'h60; bus.dmaWdata = 32'd25;
    #1;
    n_checks++; if (bus.dmaReady !== 1'b0) $display("FAIL wr_ready_early: got %0b want 0", bus.dmaReady); else n_pass++;
    tick();
    #1;
    n_checks++; if (bus.dmaReady !== 1'b1) $display("FAIL wr_ready: got %0b want 1", bus.dmaReady); else n_pass++;
    n_checks++; if (bus.memWe !== 1'b1) $display("FAIL wr_memwe: got %0b want 1", bus.memWe); else n_pass++;
    n_checks++; if (bus.memAddr !== 32'h60) $display("FAIL wr_memaddr: got %0h want 60", bus.memAddr); else n_pass++;
    n_checks++; if (bus.coreStall !== 1'b0) $display("FAIL wr_stall: got %0b want 0", bus.coreStall); else n_pass++;
    tick();
    bus.dmaValid = 1'b0;
    #1;
    n_checks++; if (mem[24] !== 32'd25) $display("FAIL wr_mem: got %0d want 25", mem[24]); else n_pass++;
    tick();
    n_checks++; if (bus.ownerDbg !== 1'b0) $display("FAIL wr_back_core: got %0b want 0", bus.ownerDbg); else n_pass++;
    drive_idle();
  endtask

  task automatic test_dma_read();
    tick();
    bus.coreReq = 1'b1; bus.coreWe = 1'b1; bus.coreAddr = 32'h64; bus.coreWdata = 32'h19;
    #1;
    n_checks++; if (bus.memWe !== 1'b1) $display("FAIL core_st_we: got %0b want 1", bus.memWe); else n_pass++;
    tick();
    bus.coreWe = 1'b0;
    #1;
    n_checks++; if (bus.coreRdata !== 32'h19) $display("FAIL core_ld: got %0h want 19", bus.coreRdata); else n_pass++;
    bus.coreReq = 1'b0;
    bus.dmaValid = 1'b1; bus.dmaWe = 1'b0; bus.dmaAddr = 32'h64;
    tick();
    #1;
    n_checks++; if (bus.dmaReady !== 1'b1) $display("FAIL rd_ready: got %0b want 1", bus.dmaReady); else n_pass++;
    n_checks++; if (bus.dmaRvalid !== 1'b0) $display("FAIL rd_rvalid_early: got %0b want 0", bus.dmaRvalid); else n_pass++;
    tick();
    bus.dmaValid = 1'b0;
    #1;
    n_checks++; if (bus.dmaRvalid !== 1'b1) $display("FAIL rd_rvalid: got %0b want 1", bus.dmaRvalid); else n_pass++;
    n_checks++; if (bus.dmaRdata !== 32'h19) $display("FAIL rd_rdata: got %0h want 19", bus.dmaRdata); else n_pass++;
    tick();
    #1;
    n_checks++; if (bus.dmaRvalid !== 1'b0) $display("FAIL rd_rvalid_pulse: got %0b want 0", bus.dmaRvalid); else n_pass++;
    n_checks++; if (bus.dmaRdata !== 32'h19) $display("FAIL rd_rdata_hold: got %0h want 19", bus.dmaRdata); else n_pass++;
    drive_idle();
  endtask

  task automatic test_starvation();
    logic exp_stall;
    logic [31:0] exp_addr;
    pulse_reset();
    tick();
    bus.coreReq = 1'b1; bus.coreWe = 1'b1; bus.coreAddr = 32'h64;
    bus.dmaValid = 1'b1; bus.dmaWe = 1'b1; bus.dmaAddr = 32'h68; bus.dmaWdata = 32'hAA;
    // 12-cycle window: 8 core cycles waiting out the starve limit, 4 DMA beats
    for (int k = 0; k < 36; k++) begin
      bus.coreWdata = k;
      exp_stall = ((k % 12) >= 8);
      exp_addr  = exp_stall ? 32'h68 : 32'h64;
      #1;
      n_checks++; if (bus.coreStall !== exp_stall) $display("FAIL starve_stall[%0d]: got %0b want %0b", k, bus.coreStall, exp_stall); else n_pass++;
      n_checks++; if (bus.memAddr !== exp_addr) $display("FAIL starve_addr[%0d]: got %0h want %0h", k, bus.memAddr, exp_addr); else n_pass++;
      tick();
    end
`ifdef ARB_STALL_COUNT_EN
    exp_stall_count = 32'd12;
`else
    exp_stall_count = 32'd0;
`endif
    n_checks++; if (bus.stallCount !== exp_stall_count) $display("FAIL stall_count: got %0d want %0d", bus.stallCount, exp_stall_count); else n_pass++;
    n_checks++; if (mem[26] !== 32'hAA) $display("FAIL starve_dma_mem: got %0h want aa", mem[26]); else n_pass++;
    drive_idle();
  endtask

  task automatic test_back_to_back();
    tick();
    bus.dmaValid = 1'b1; bus.dmaWe = 1'b1; bus.dmaAddr = 32'h80; bus.dmaWdata = 32'd100;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.dmaAddr  = 32'h80 + 32'(i * 4);
      bus.dmaWdata = 32'(100 + i);
      #1;
      n_checks++; if (bus.dmaReady !== 1'b1) $display("FAIL b2b_ready[%0d]: got %0b want 1", i, bus.dmaReady); else n_pass++;
      n_checks++; if (bus.coreStall !== 1'b0) $display("FAIL b2b_stall[%0d]: got %0b want 0", i, bus.coreStall); else n_pass++;
      tick();
    end
    bus.dmaValid = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (mem[32 + i] !== 32'(100 + i)) $display("FAIL b2b_mem[%0d]: got %0d want %0d", i, mem[32 + i], 100 + i); else n_pass++;
    end
    tick();
    drive_idle();
  endtask

  task automatic test_reset_mid_burst();
    tick();
    bus.dmaValid = 1'b1; bus.dmaWe = 1'b0; bus.dmaAddr = 32'h64;
    tick();
    tick();
    tick();
    bus.coreReq = 1'b1; bus.coreWe = 1'b1; bus.coreAddr = 32'h70; bus.coreWdata = 32'h7;
    #1;
    n_checks++; if (bus.coreStall !== 1'b1) $display("FAIL mid_pre_stall: got %0b want 1", bus.coreStall); else n_pass++;
    n_checks++; if (bus.dmaRvalid !== 1'b1) $display("FAIL mid_pre_rvalid: got %0b want 1", bus.dmaRvalid); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.dmaReady !== 1'b0) $display("FAIL mid_ready: got %0b want 0", bus.dmaReady); else n_pass++;
    n_checks++; if (bus.coreStall !== 1'b0) $display("FAIL mid_stall: got %0b want 0", bus.coreStall); else n_pass++;
    n_checks++; if (bus.dmaRvalid !== 1'b0) $display("FAIL mid_rvalid: got %0b want 0", bus.dmaRvalid); else n_pass++;
    n_checks++; if (bus.memWe !== 1'b1) $display("FAIL mid_memwe: got %0b want 1", bus.memWe); else n_pass++;
    tick();
    tick();
    reset = 1'b1;
    bus.coreReq = 1'b0;
    #1;
    n_checks++; if (bus.ownerDbg !== 1'b0) $display("FAIL mid_owner: got %0b want 0", bus.ownerDbg); else n_pass++;
    n_checks++; if (bus.dmaReady !== 1'b0) $display("FAIL mid_post_ready: got %0b want 0", bus.dmaReady); else n_pass++;
    drive_idle();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    test_reset();
    test_dma_write_idle();
    test_dma_read();
    test_starvation();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
